a51_stream_engine: RTL

- Parametrised A5/1 stream-cipher engine: the successor to the single-bit A51 key-load/XOR block.
- Performs full GSM initialisation (64-bit key, 22-bit frame number, 100 mixing steps), then XORs plaintext with keystream DATA_W bits per cycle under valid/ready flow control.
- Emits one 228-bit burst per frame; optional automatic frame-number advance and re-initialisation.
- Sits between the burst framer and the radio modem datapath.

---
 rtl/a51_stream_engine.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/a51_stream_engine.sv
// Purpose : A5/1 stream-cipher engine. Runs the GSM key/frame load and
//           MIX_STEPS warm-up, then XORs DATA_W plaintext bits per beat with
//           keystream for one BURST_BITS burst per frame.
// Latency : start at edge t -> in_ready first high after edge t+86+MIX_STEPS;
//           each accepted beat appears on out_data one cycle later.
// Backpressure: in_ready drops while out_valid && !out_ready; out_data holds.
// Ports   : clk/rst (async, active-high); start/key/frame kick off a frame;
//           in_valid/in_ready/in_data plaintext side; out_valid/out_ready/
//           out_data ciphertext side; busy = not idle; frame_done pulses
//           the cycle after the last beat of a burst is accepted.
module a51_stream_engine #(
    parameter int DATA_W     = 1,
    parameter int BURST_BITS = 228,
    parameter int MIX_STEPS  = 100,
    parameter int AUTO_FRAME = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       key,
    input  logic [21:0]       frame,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int BEATS   = BURST_BITS / DATA_W;
    localparam int CNT_LIM = (BEATS > MIX_STEPS) ? ((BEATS > 64) ? BEATS : 64)
                                                 : ((MIX_STEPS > 64) ? MIX_STEPS : 64);
    localparam int CNT_W   = $clog2(CNT_LIM) + 1;

    localparam logic [CNT_W-1:0] C_KEY_LAST   = CNT_W'(63);
    localparam logic [CNT_W-1:0] C_FRAME_LAST = CNT_W'(21);
    localparam logic [CNT_W-1:0] C_MIX_LAST   = CNT_W'(MIX_STEPS - 1);
    localparam logic [CNT_W-1:0] C_BEAT_LAST  = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_FRAME,
        S_MIX,
        S_STREAM
    } state_t;

    // The three LFSRs live in one 64-bit word: R1 = [63:45], R2 = [44:23],
    // R3 = [22:0]. That keeps the step functions single-argument.
    function automatic logic [18:0] f_step1(input logic [18:0] r);
        return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18]};
    endfunction

    function automatic logic [21:0] f_step2(input logic [21:0] r);
        return {r[20:0], r[20] ^ r[21]};
    endfunction

    function automatic logic [22:0] f_step3(input logic [22:0] r);
        return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22]};
    endfunction

    // Unconditional step of all three registers, then the load bit is
    // folded into bit 0 of each.
    function automatic logic [63:0] f_load_step(input logic [63:0] s, input logic b);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        r1 = f_step1(s[63:45]);
        r2 = f_step2(s[44:23]);
        r3 = f_step3(s[22:0]);
        r1[0] = r1[0] ^ b;
        r2[0] = r2[0] ^ b;
        r3[0] = r3[0] ^ b;
        return {r1, r2, r3};
    endfunction

    // Stop/go step: only registers whose clock bit agrees with the majority move.
    function automatic logic [63:0] f_maj_step(input logic [63:0] s);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic        c1, c2, c3, m;
        r1 = s[63:45];
        r2 = s[44:23];
        r3 = s[22:0];
        c1 = r1[8];
        c2 = r2[10];
        c3 = r3[10];
        m  = (c1 & c2) | (c1 & c3) | (c2 & c3);
        if (c1 == m) r1 = f_step1(r1);
        if (c2 == m) r2 = f_step2(r2);
        if (c3 == m) r3 = f_step3(r3);
        return {r1, r2, r3};
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [63:0]         r_key;
    logic [21:0]         r_frame;
    logic [63:0]         r_lfsr;
    logic                r_out_vld;
    logic [DATA_W-1:0]   r_out_dat;
    logic                r_frame_done;

    logic                w_in_rdy;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_load_bit;
    logic [63:0]         w_ks_lfsr;
    logic [DATA_W-1:0]   w_ks;

    assign w_in_rdy = (r_state == S_STREAM) && (!r_out_vld || out_ready);
    assign w_accept = in_valid && w_in_rdy;

    // Key byte j occupies key[63-8j -: 8], consumed LSB first, so the bit
    // index is {~byte, bit}. Frame bits are consumed in natural order.
    assign w_load_bit = (r_state == S_LOAD_KEY) ? r_key[{~r_cnt[5:3], r_cnt[2:0]}]
                                                : r_frame[r_cnt[4:0]];

    // DATA_W majority steps chained combinationally; keystream bit k is the
    // output after step k and lands MSB-first.
    always_comb begin
        w_ks_lfsr = r_lfsr;
        w_ks      = '0;
        for (int k = 0; k < DATA_W; k++) begin
            w_ks_lfsr            = f_maj_step(w_ks_lfsr);
            w_ks[DATA_W - 1 - k] = w_ks_lfsr[63] ^ w_ks_lfsr[44] ^ w_ks_lfsr[22];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_beat = 1'b0;
        case (r_state)
            S_IDLE:       if (start) w_state_nxt = S_LOAD_KEY;
            S_LOAD_KEY:   if (r_cnt == C_KEY_LAST) w_state_nxt = S_LOAD_FRAME;
            S_LOAD_FRAME: if (r_cnt == C_FRAME_LAST) w_state_nxt = S_MIX;
            S_MIX:        if (r_cnt == C_MIX_LAST) w_state_nxt = S_STREAM;
            S_STREAM: begin
                if (w_accept && (r_cnt == C_BEAT_LAST)) begin
                    w_last_beat = 1'b1;
                    w_state_nxt = (AUTO_FRAME != 0) ? S_LOAD_KEY : S_IDLE;
                end
            end
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_key        <= '0;
            r_frame      <= '0;
            r_lfsr       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_beat;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_key   <= key;
                        r_frame <= frame;
                        r_lfsr  <= '0;
                    end
                end
                S_LOAD_KEY, S_LOAD_FRAME: begin
                    r_lfsr <= f_load_step(r_lfsr, w_load_bit);
                    r_cnt  <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
                end
                S_MIX: begin
                    r_lfsr <= f_maj_step(r_lfsr);
                    r_cnt  <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            // Registers restart from zero for the next load;
                            // in auto mode the frame number moves on (mod 2^22).
                            r_cnt  <= '0;
                            r_lfsr <= '0;
                            if (AUTO_FRAME != 0) r_frame <= r_frame + 22'd1;
                        end else begin
                            r_cnt  <= r_cnt + 1'b1;
                            r_lfsr <= w_ks_lfsr;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Output register: loads on acceptance, drains on out_ready, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else if (w_accept) begin
            r_out_vld <= 1'b1;
            r_out_dat <= in_data ^ w_ks;
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign in_ready   = w_in_rdy;
    assign out_valid  = r_out_vld;
    assign out_data   = r_out_dat;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule
